darksimv_mon_buffer: RTL and testbench

DARKSIMV_MON_BUFFER -- requirements
Module: darksimv_mon_buffer

---
 rtl/darksimv_mon_pkg.sv | 25 ++
 rtl/darksimv_mon_fifo_mem.sv | 36 +++
 rtl/darksimv_mon_buffer.sv | 182 ++++++++++++++++++
 tb/tb_darksimv_mon_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/darksimv_mon_pkg.sv
// Shared types and constants for the darksimv bus monitor buffer.
// Holds the captured-sample record and the default FIFO depth.
package darksimv_mon_pkg;

  localparam int unsigned MON_DEPTH_DEF = 16;
  localparam int unsigned MON_WORD_W    = 32;
  localparam int unsigned MON_DLEN_W    = 3;
  localparam int unsigned MON_RSVD_W    = 6;

  // One captured core bus sample; rsvd pads the record to a fixed 171-bit layout
  typedef struct packed {
    logic [MON_WORD_W-1:0] idata;
    logic [MON_WORD_W-1:0] iaddr;
    logic [MON_WORD_W-1:0] datai;
    logic [MON_WORD_W-1:0] datao;
    logic [MON_WORD_W-1:0] daddr;
    logic [MON_DLEN_W-1:0] dlen;
    logic                  drd;
    logic                  dwr;
    logic [MON_RSVD_W-1:0] rsvd;
  } mon_entry_t;

  localparam int unsigned MON_ENTRY_W = $bits(mon_entry_t);

endpackage

// File: rtl/darksimv_mon_fifo_mem.sv
// Storage array for the monitor FIFO: one synchronous write port, one
// asynchronous read port. No reset; validity is tracked by the pointer logic.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write index
//   wdata - entry to store
//   raddr - read index
//   rdata - entry at raddr (combinational)
module darksimv_mon_fifo_mem
  import darksimv_mon_pkg::*;
#(
  parameter int unsigned DEPTH = MON_DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  mon_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output mon_entry_t    rdata
);

  mon_entry_t mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Async read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/darksimv_mon_buffer.sv
// Show-ahead capture FIFO for core bus samples seen by the HVL monitor.
// Samples are captured while CAP_EN=1 and HLT=0; a capture into a full FIFO
// with no same-cycle pop is dropped and sets the sticky OVF flag.
// The head entry is held in a register so O_* are registered outputs.
// Optional build macro: DARKSIMV_MON_DROP_CNT_EN adds DROP_CNT, a saturating
// 16-bit count of dropped samples.
// Ports:
//   CLK, RES                    - clock, synchronous active-high reset
//   CAP_EN, HLT                 - capture enable, core halt (blocks capture)
//   IDATA..DWR                  - core bus sample fields
//   POP                         - consume head entry (ignored when empty)
//   O_VALID, O_*                - head entry
//   LEVEL                       - occupancy
//   OVF                         - sticky overflow
//   DROP_CNT                    - dropped-sample count (macro only)
module darksimv_mon_buffer
  import darksimv_mon_pkg::*;
#(
  parameter int unsigned DEPTH = MON_DEPTH_DEF
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic                    CAP_EN,
  input  logic                    HLT,
  input  logic [31:0]             IDATA,
  input  logic [31:0]             IADDR,
  input  logic [31:0]             DATAI,
  input  logic [31:0]             DATAO,
  input  logic [31:0]             DADDR,
  input  logic [2:0]              DLEN,
  input  logic                    DRD,
  input  logic                    DWR,
  input  logic                    POP,
  output logic                    O_VALID,
  output logic [31:0]             O_IDATA,
  output logic [31:0]             O_IADDR,
  output logic [31:0]             O_DATAI,
  output logic [31:0]             O_DATAO,
  output logic [31:0]             O_DADDR,
  output logic [2:0]              O_DLEN,
  output logic                    O_DRD,
  output logic                    O_DWR,
  output logic [$clog2(DEPTH):0]  LEVEL,
  output logic                    OVF
`ifdef DARKSIMV_MON_DROP_CNT_EN
  ,
  output logic [15:0]             DROP_CNT
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nx;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic          valid;
  logic          ovf;
  mon_entry_t    head_q;
  mon_entry_t    head_next;
  mon_entry_t    sample;
  mon_entry_t    rd_data;
  logic          cap;
  logic          full;
  logic          empty;
  logic          pop_ok;
  logic          push;
  logic          drop;
  logic [MON_RSVD_W-1:0] unused_rsvd;

  // Pack the live bus sample
  always_comb begin
    sample       = '0;
    sample.idata = IDATA;
    sample.iaddr = IADDR;
    sample.datai = DATAI;
    sample.datao = DATAO;
    sample.daddr = DADDR;
    sample.dlen  = DLEN;
    sample.drd   = DRD;
    sample.dwr   = DWR;
  end

  // Push/pop/drop qualification; a pop frees the slot the push needs when full
  assign cap       = CAP_EN & ~HLT;
  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign pop_ok    = POP & ~empty;
  assign push      = cap & (~full | pop_ok);
  assign drop      = cap & full & ~pop_ok;
  assign rd_ptr_nx = rd_ptr + AW'(1);

  darksimv_mon_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (sample),
    .raddr (rd_ptr_nx),
    .rdata (rd_data)
  );

  // Next occupancy and next head value. The head register bypasses the
  // array when the incoming sample becomes the head on the same edge.
  always_comb begin
    level_next = level;
    head_next  = head_q;
    unique case ({push, pop_ok})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
    if (pop_ok) begin
      if (level == LW'(1)) begin
        if (push) begin
          head_next = sample;
        end
      end else begin
        head_next = rd_data;
      end
    end else if (empty && push) begin
      head_next = sample;
    end
  end

  // Pointer, occupancy, head and flag registers
  always_ff @(posedge CLK) begin
    if (RES) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
      head_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_nx;
      end
      level  <= level_next;
      valid  <= (level_next != '0);
      ovf    <= ovf | drop;
      head_q <= head_next;
    end
  end

`ifdef DARKSIMV_MON_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating dropped-sample counter
  always_ff @(posedge CLK) begin
    if (RES) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign DROP_CNT = drop_cnt;
`endif

  assign unused_rsvd = head_q.rsvd;

  assign O_VALID = valid;
  assign O_IDATA = head_q.idata;
  assign O_IADDR = head_q.iaddr;
  assign O_DATAI = head_q.datai;
  assign O_DATAO = head_q.datao;
  assign O_DADDR = head_q.daddr;
  assign O_DLEN  = head_q.dlen;
  assign O_DRD   = head_q.drd;
  assign O_DWR   = head_q.dwr;
  assign LEVEL   = level;
  assign OVF     = ovf;

endmodule

// File: tb/tb_darksimv_mon_buffer.sv
// Directed self-checking bench for darksimv_mon_buffer (DEPTH=16).
module tb_darksimv_mon_buffer;

  localparam int unsigned DEPTH = 16;

  logic        CLK;
  logic        RES;
  logic        CAP_EN;
  logic        HLT;
  logic [31:0] IDATA, IADDR, DATAI, DATAO, DADDR;
  logic [2:0]  DLEN;
  logic        DRD, DWR, POP;
  logic        O_VALID;
  logic [31:0] O_IDATA, O_IADDR, O_DATAI, O_DATAO, O_DADDR;
  logic [2:0]  O_DLEN;
  logic        O_DRD, O_DWR;
  logic [4:0]  LEVEL;
  logic        OVF;
`ifdef DARKSIMV_MON_DROP_CNT_EN
  logic [15:0] DROP_CNT;
`endif

  int n_tests;
  int n_fail;

  darksimv_mon_buffer #(.DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RES     (RES),
    .CAP_EN  (CAP_EN),
    .HLT     (HLT),
    .IDATA   (IDATA),
    .IADDR   (IADDR),
    .DATAI   (DATAI),
    .DATAO   (DATAO),
    .DADDR   (DADDR),
    .DLEN    (DLEN),
    .DRD     (DRD),
    .DWR     (DWR),
    .POP     (POP),
    .O_VALID (O_VALID),
    .O_IDATA (O_IDATA),
    .O_IADDR (O_IADDR),
    .O_DATAI (O_DATAI),
    .O_DATAO (O_DATAO),
    .O_DADDR (O_DADDR),
    .O_DLEN  (O_DLEN),
    .O_DRD   (O_DRD),
    .O_DWR   (O_DWR),
    .LEVEL   (LEVEL),
    .OVF     (OVF)
`ifdef DARKSIMV_MON_DROP_CNT_EN
    ,
    .DROP_CNT(DROP_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_sample(input int i);
    IDATA = ~32'(i);
    IADDR = 32'(i) << 2;
    DATAI = 32'(i) + 32'h5000;
    DATAO = 32'(i) + 32'h6000;
    DADDR = 32'(i);
    DLEN  = 3'(i);
    DRD   = i[0];
    DWR   = ~i[0];
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RES = 1'b1; CAP_EN = 1'b0; HLT = 1'b0; POP = 1'b0;
    set_sample(0);

    // Reset state
    tick();
    tick();
    RES = 1'b0;
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_valid", 32'(O_VALID), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_oiaddr", O_IADDR, 32'd0);

    // Single capture on the first edge after reset
    set_sample(0);
    IADDR = 32'h0000_0100;
    IDATA = 32'h0000_0013;
    CAP_EN = 1'b1;
    tick();
    CAP_EN = 1'b0;
    chk("single_valid", 32'(O_VALID), 32'd1);
    chk("single_iaddr", O_IADDR, 32'h100);
    chk("single_idata", O_IDATA, 32'h13);
    chk("single_level", 32'(LEVEL), 32'd1);
    POP = 1'b1;
    tick();
    chk("single_pop_valid", 32'(O_VALID), 32'd0);
    chk("single_pop_level", 32'(LEVEL), 32'd0);

    // Pop on empty FIFO is ignored
    tick();
    POP = 1'b0;
    chk("emptypop_level", 32'(LEVEL), 32'd0);
    chk("emptypop_valid", 32'(O_VALID), 32'd0);

    // Halt blocks capture
    CAP_EN = 1'b1;
    HLT = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    CAP_EN = 1'b0;
    HLT = 1'b0;
    chk("hlt_level", 32'(LEVEL), 32'd0);
    chk("hlt_valid", 32'(O_VALID), 32'd0);

    // Empty FIFO: push and pop together stores the push
    set_sample(32'hAA);
    CAP_EN = 1'b1;
    POP = 1'b1;
    tick();
    CAP_EN = 1'b0;
    chk("emptypp_level", 32'(LEVEL), 32'd1);
    chk("emptypp_daddr", O_DADDR, 32'hAA);
    tick();
    POP = 1'b0;
    chk("emptypp_drain", 32'(LEVEL), 32'd0);

    // Fill with 20 samples, 4 dropped
    CAP_EN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_sample(32'h1000 + i);
      tick();
    end
    CAP_EN = 1'b0;
    chk("fill_level", 32'(LEVEL), 32'd16);
    chk("fill_ovf", 32'(OVF), 32'd1);
`ifdef DARKSIMV_MON_DROP_CNT_EN
    chk("fill_dropcnt", 32'(DROP_CNT), 32'd4);
`endif
    chk("fill_head_idata", O_IDATA, ~32'h1000);
    chk("fill_head_iaddr", O_IADDR, 32'h4000);
    chk("fill_head_datai", O_DATAI, 32'h6000);
    chk("fill_head_datao", O_DATAO, 32'h7000);
    chk("fill_head_dlen", 32'(O_DLEN), 32'd0);
    chk("fill_head_drd", 32'(O_DRD), 32'd0);
    chk("fill_head_dwr", 32'(O_DWR), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_order_%0d", i), O_DADDR, 32'h1000 + 32'(i));
      POP = 1'b1;
      tick();
      POP = 1'b0;
    end
    chk("fill_drained_valid", 32'(O_VALID), 32'd0);
    chk("fill_ovf_sticky", 32'(OVF), 32'd1);

    // Reset mid-operation with LEVEL=7 and OVF set
    CAP_EN = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_sample(32'h3000 + i);
      tick();
    end
    chk("premid_level", 32'(LEVEL), 32'd7);
    chk("premid_ovf", 32'(OVF), 32'd1);
    POP = 1'b1;
    RES = 1'b1;
    tick();
    RES = 1'b0;
    CAP_EN = 1'b0;
    POP = 1'b0;
    chk("midrst_level", 32'(LEVEL), 32'd0);
    chk("midrst_valid", 32'(O_VALID), 32'd0);
    chk("midrst_ovf", 32'(OVF), 32'd0);
    chk("midrst_odaddr", O_DADDR, 32'd0);
`ifdef DARKSIMV_MON_DROP_CNT_EN
    chk("midrst_dropcnt", 32'(DROP_CNT), 32'd0);
`endif

    // Full FIFO with simultaneous push and pop
    CAP_EN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_sample(32'h2000 + i);
      tick();
    end
    chk("fullpp_pre_level", 32'(LEVEL), 32'd16);
    set_sample(32'h2FFF);
    POP = 1'b1;
    tick();
    CAP_EN = 1'b0;
    POP = 1'b0;
    chk("fullpp_level", 32'(LEVEL), 32'd16);
    chk("fullpp_ovf", 32'(OVF), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpp_order_%0d", i), O_DADDR,
          (i == 15) ? 32'h2FFF : 32'h2001 + 32'(i));
      POP = 1'b1;
      tick();
      POP = 1'b0;
    end
    chk("fullpp_empty", 32'(LEVEL), 32'd0);

    // Pointer wrap: streaming push+pop at LEVEL=1, DADDR = 0..39
    set_sample(0);
    CAP_EN = 1'b1;
    tick();
    for (int i = 1; i < 40; i++) begin
      chk($sformatf("wrap_%0d", i - 1), O_DADDR, 32'(i - 1));
      set_sample(i);
      POP = 1'b1;
      tick();
    end
    CAP_EN = 1'b0;
    chk("wrap_39", O_DADDR, 32'd39);
    chk("wrap_level", 32'(LEVEL), 32'd1);
    tick();
    POP = 1'b0;
    chk("wrap_end_level", 32'(LEVEL), 32'd0);
    chk("wrap_end_ovf", 32'(OVF), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
